// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer and its byte-lane helpers.
//   - Store size encodings (byte / half / word).
//   - Buffered entry layout: word address, lane-aligned data, byte enables.
package store_buffer_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Loads are checked at word granularity: every lane of the word counts.
  localparam logic [3:0] LD_LANES = 4'b1111;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational byte-lane aligner for stores.
// Ports:
//   offset_i  in  2   st_addr[1:0] of the store
//   size_i    in  2   SZ_BYTE / SZ_HALF / SZ_WORD (2'b11 illegal)
//   data_i    in  32  rs2 value; only the low byte/half/word is used
//   wdata_o   out 32  data shifted into its lanes, other lanes zero
//   be_o      out 4   byte enables matching wdata_o
//   illegal_o out 1   misaligned access or illegal size
module store_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        illegal_o
);

  logic [4:0] shamt_s;
  assign shamt_s = {offset_i, 3'b000};

  // Lane placement and legality check; illegal stores drive no lanes.
  always_comb begin
    wdata_o   = 32'h0000_0000;
    be_o      = 4'b0000;
    illegal_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {24'h00_0000, data_i[7:0]} << shamt_s;
      end
      SZ_HALF: begin
        if (offset_i[0]) begin
          illegal_o = 1'b1;
        end else begin
          be_o    = 4'b0011 << offset_i;
          wdata_o = {16'h0000, data_i[15:0]} << shamt_s;
        end
      end
      SZ_WORD: begin
        if (offset_i != 2'b00) begin
          illegal_o = 1'b1;
        end else begin
          be_o    = 4'b1111;
          wdata_o = data_i;
        end
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the EX/MEM store request and data memory.
// Aligns stores into byte lanes, queues legal ones, drains them over a
// req/ack handshake, flags rejected stores and reports load overlap.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   st_valid/st_ready            store request handshake
//   st_addr, st_data, st_size    store byte address, rs2 value, size
//   mem_req/mem_ack              head entry handshake to data memory
//   mem_addr, mem_wdata, mem_be  head entry word address, data, enables
//   misalign, err_addr           rejected-store pulse and its address
//   ld_addr, ld_hit              load word overlap check
//   empty                        no entries buffered
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        misalign,
  output logic [31:0] err_addr,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t          entries_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               misalign_q;
  logic [31:0]        err_addr_q;

  logic [31:0] al_wdata_s;
  logic [3:0]  al_be_s;
  logic        al_illegal_s;
  logic        full_s, accept_s, push_s, pop_s;
  sb_entry_t   head_s;
  logic [1:0]  unused_ld_off;

  store_align u_align (
    .offset_i  (st_addr[1:0]),
    .size_i    (st_size),
    .data_i    (st_data),
    .wdata_o   (al_wdata_s),
    .be_o      (al_be_s),
    .illegal_o (al_illegal_s)
  );

  assign full_s   = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full_s;
  assign accept_s = st_valid && st_ready;
  assign push_s   = accept_s && !al_illegal_s;
  assign mem_req  = !empty;
  assign pop_s    = mem_req && mem_ack;

  // Head outputs are forced to zero when empty so stale drained data never shows.
  assign head_s    = entries_q[head_q];
  assign mem_addr  = empty ? 32'h0000_0000 : {head_s.waddr, 2'b00};
  assign mem_wdata = empty ? 32'h0000_0000 : head_s.data;
  assign mem_be    = empty ? 4'b0000 : head_s.be;

  assign misalign = misalign_q;
  assign err_addr = err_addr_q;

  // Load offset bits are irrelevant: the overlap check is word-wide.
  assign unused_ld_off = ld_addr[1:0];

  // Occupancy next state; simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Load overlap against every valid entry.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (entries_q[i].waddr == ld_addr[31:2]) &&
          ((entries_q[i].be & LD_LANES) != 4'b0000)) begin
        ld_hit = 1'b1;
      end else begin
        ld_hit = ld_hit;
      end
    end
  end

  // FIFO storage, pointers, occupancy and rejected-store reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      err_addr_q <= 32'h0000_0000;
    end else begin
      // Push and pop never target the same slot: push needs !full, pop needs !empty.
      if (push_s) begin
        entries_q[tail_q] <= '{waddr: st_addr[31:2], data: al_wdata_s, be: al_be_s};
        valid_q[tail_q]   <= 1'b1;
        tail_q            <= tail_q + PTR_W'(1);
      end
      if (pop_s) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      count_q    <= count_d;
      misalign_q <= accept_s && al_illegal_s;
      if (accept_s && al_illegal_s) begin
        err_addr_q <= st_addr;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [31:0] err_addr;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        empty;

  int vectors = 0;
  int errors  = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .misalign(misalign), .err_addr(err_addr),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    vectors++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", st_ready); end
    vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    vectors++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
    vectors++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL reset_be got %b want 0000", mem_be); end
    vectors++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
    vectors++; if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_err got %h want 0", err_addr); end
    vectors++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL reset_ldhit got %b want 0", ld_hit); end
  endtask

  task automatic test_byte();
    do_push(32'h0000_0103, 32'hABCD_EF17, 2'b00);
    vectors++; if (mem_req !== 1'b1) begin errors++; $display("FAIL byte_req got %b want 1", mem_req); end
    vectors++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL byte_addr got %h want 00000100", mem_addr); end
    vectors++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL byte_be got %b want 1000", mem_be); end
    vectors++; if (mem_wdata !== 32'h1700_0000) begin errors++; $display("FAIL byte_wdata got %h want 17000000", mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL byte_drain_empty got %b want 1", empty); end
  endtask

  task automatic test_half();
    do_push(32'h0000_0102, 32'hABCD_EF17, 2'b01);
    vectors++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL half_be got %b want 1100", mem_be); end
    vectors++; if (mem_wdata !== 32'hEF17_0000) begin errors++; $display("FAIL half_wdata got %h want EF170000", mem_wdata); end
    vectors++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL half_addr got %h want 00000100", mem_addr); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    // Low half at offset 0 of another word.
    do_push(32'h0000_0040, 32'h1234_5678, 2'b01);
    vectors++; if (mem_be !== 4'b0011) begin errors++; $display("FAIL half0_be got %b want 0011", mem_be); end
    vectors++; if (mem_wdata !== 32'h0000_5678) begin errors++; $display("FAIL half0_wdata got %h want 00005678", mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL half_drain_empty got %b want 1", empty); end
  endtask

  task automatic test_misalign();
    do_push(32'h0000_0200, 32'h0, 2'b11);
    vectors++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_size_pulse got %b want 1", misalign); end
    vectors++; if (err_addr !== 32'h0000_0200) begin errors++; $display("FAIL mis_size_err got %h want 00000200", err_addr); end
    do_push(32'h0000_0101, 32'h1111_2222, 2'b10);
    vectors++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_word_pulse got %b want 1", misalign); end
    vectors++; if (err_addr !== 32'h0000_0101) begin errors++; $display("FAIL mis_word_err got %h want 00000101", err_addr); end
    do_push(32'h0000_0103, 32'h3333_4444, 2'b01);
    vectors++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_half_pulse got %b want 1", misalign); end
    vectors++; if (err_addr !== 32'h0000_0103) begin errors++; $display("FAIL mis_half_err got %h want 00000103", err_addr); end
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL mis_empty got %b want 1", empty); end
    vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_req got %b want 0", mem_req); end
    tick();
    vectors++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse_end got %b want 0", misalign); end
    vectors++; if (err_addr !== 32'h0000_0103) begin errors++; $display("FAIL mis_err_hold got %h want 00000103", err_addr); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] addrs [4];
    logic [31:0] datas [4];
    addrs = '{32'h10, 32'h14, 32'h18, 32'h1C};
    datas = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (st_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b want 1", k, st_ready); end
      do_push(addrs[k], datas[k], 2'b10);
      vectors++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fill_head_%0d got %h want 00000010", k, mem_addr); end
    end
    vectors++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", st_ready); end
    tick();
    vectors++; if (mem_wdata !== 32'hA0A0_0001) begin errors++; $display("FAIL stall_wdata got %h want A0A00001", mem_wdata); end
    vectors++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL stall_be got %b want 1111", mem_be); end
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (mem_addr !== addrs[k]) begin errors++; $display("FAIL drain_addr_%0d got %h want %h", k, mem_addr, addrs[k]); end
      vectors++; if (mem_wdata !== datas[k]) begin errors++; $display("FAIL drain_wdata_%0d got %h want %h", k, mem_wdata, datas[k]); end
      tick();
      if (k == 0) begin
        vectors++; if (st_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b want 1", st_ready); end
      end
    end
    mem_ack = 1'b0;
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty); end
    vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL drain_req got %b want 0", mem_req); end
  endtask

  task automatic test_ld_hit();
    ld_addr  = 32'h0000_0200;
    st_valid = 1'b1;
    st_addr  = 32'h0000_0201;
    st_data  = 32'h0000_0055;
    st_size  = 2'b00;
    #1;
    vectors++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL ld_same_cycle got %b want 0", ld_hit); end
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    vectors++; if (ld_hit !== 1'b1) begin errors++; $display("FAIL ld_hit_200 got %b want 1", ld_hit); end
    vectors++; if (mem_wdata !== 32'h0000_5500) begin errors++; $display("FAIL ld_wdata got %h want 00005500", mem_wdata); end
    ld_addr = 32'h0000_0204;
    #1;
    vectors++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL ld_hit_204 got %b want 0", ld_hit); end
    ld_addr = 32'h0000_0203;
    #1;
    vectors++; if (ld_hit !== 1'b1) begin errors++; $display("FAIL ld_hit_203 got %b want 1", ld_hit); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    vectors++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL ld_after_drain got %b want 0", ld_hit); end
  endtask

  task automatic test_reset_mid_drain();
    mem_ack = 1'b0;
    do_push(32'h0000_0300, 32'h1, 2'b10);
    do_push(32'h0000_0304, 32'h2, 2'b10);
    do_push(32'h0000_0308, 32'h3, 2'b10);
    vectors++; if (mem_req !== 1'b1) begin errors++; $display("FAIL pre_rst_req got %b want 1", mem_req); end
    ld_addr = 32'h0000_0304;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL post_rst_req_%0d got %b want 0", k, mem_req); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    st_valid = 1'b0;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    st_size  = 2'b00;
    mem_ack  = 1'b0;
    ld_addr  = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_byte();
    test_half();
    test_misalign();
    test_fill_drain();
    test_ld_hit();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store path stage between the EX/MEM store request and the data memory write port. It takes a byte, half or word store, aligns it into the correct byte lanes with matching byte enables, and queues it in a small in-order FIFO. It drains that FIFO to data memory over a req/ack handshake. It also flags misaligned stores and reports whether a pending store overlaps a load address, so the load path can stall.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; a power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- st_valid  in  1  a store request is presented.
- st_ready  out  1  the buffer can accept a store this cycle.
- st_addr  in  32  byte address of the store.
- st_data  in  32  rs2 value; only the low byte/half/word is used.
- st_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_req  out  1  head entry is presented to memory.
- mem_ack  in  1  memory accepts the head entry this cycle.
- mem_addr  out  32  word address of the head entry; bits [1:0] are always 0.
- mem_wdata  out  32  lane-aligned write data; disabled lanes are 0.
- mem_be  out  4  byte enables; bit k selects bits [8k+7:8k].
- misalign  out  1  one-cycle pulse on a rejected store.
- err_addr  out  32  st_addr of the last rejected store.
- ld_addr  in  32  byte address of the load in MEM.
- ld_hit  out  1  a buffered entry shares ld_addr's word and byte lanes.
- empty  out  1  no entries buffered.

## Operation
- Accept = st_valid && st_ready; st_ready = !full. There is no bypass, so a push while full is impossible.
- Alignment uses o = st_addr[1:0]:
  - byte: be = 4'b0001 << o, data[7:0] placed in lane o.
  - half: legal only if o[0] = 0; be = 4'b0011 << o, data[15:0] placed in lanes o and o+1.
  - word: legal only if o = 0; be = 4'b1111, data unchanged.
- An accepted illegal store (bad alignment or size 11) is consumed but not enqueued. misalign pulses the next cycle and err_addr captures st_addr.
- A legal accepted store writes {st_addr[31:2], wdata, be} at the tail.
- The head is presented whenever the buffer is non-empty: mem_req = !empty, and mem_addr, mem_wdata and mem_be come directly from the head entry.
- The head pops on mem_req && mem_ack. Entries drain strictly in acceptance order.
- A push and a pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH; a count of DEPTH+1 values distinguishes full from empty.
- ld_hit is combinational: OR over valid entries of (entry word == ld_addr[31:2] && entry be has any lane set in the load's lanes). Load lanes are taken as 4'b1111, a conservative word-level check.

## Timing
- Reset values: empty = 1, st_ready = 1, mem_req = 0, mem_wdata = 0, mem_be = 0, mem_addr = 0, misalign = 0, err_addr = 0, ld_hit = 0. All entries are invalid.
- Reset mid-drain discards every entry, including an un-acked head.
- Latency: a store accepted at edge N has mem_req = 1 at cycle N+1 at the earliest, when the buffer was empty.
- While mem_req && !mem_ack, mem_addr, mem_wdata and mem_be hold stable.
- With continuous ack, throughput is one store per cycle.
- st_ready falls in the cycle after the accept that fills the buffer. It rises in the cycle after the first pop.
- ld_hit reflects buffer contents as of the current cycle. A store accepted this cycle is not seen until the next cycle.

## Structure
- Shared package holds:
  - SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - The entry layout: 30-bit word address, 32-bit data, 4-bit be.
- Sub-module store_align: combinational; inputs st_addr[1:0], st_size, st_data; outputs wdata, be, illegal. Reused by any future byte-lane logic.
- The FIFO array, pointers, counter and ld_hit compare are inline in store_buffer.

## Test plan
- Byte store, st_addr 0x103, data 0xABCDEF17 -> mem_addr 0x100, be 4'b1000, wdata 0x17000000, mem_req high at the next cycle.
- Half store, st_addr 0x102, data 0xABCDEF17 -> be 4'b1100, wdata 0xEF170000.
- Word store at 0x101 and half store at 0x103 -> two misalign pulses, err_addr ends at 0x103, empty stays 1, no mem_req.
- Hold mem_ack = 0 and push 4 word stores to 0x10, 0x14, 0x18, 0x1C -> st_ready = 0 after the 4th and mem outputs stable. Then ack every cycle -> drains in order 0x10..0x1C, st_ready returns, empty = 1 after the 4th ack.
- Buffered byte store to 0x201 and ld_addr = 0x200 -> ld_hit = 1. ld_addr = 0x204 -> ld_hit = 0.
- Fill 3 entries, assert rst for one cycle with mem_ack = 0 -> all reset values restored and no further mem_req.
